// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the gated BCD frequency counter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GATE  = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Gate counter width; never narrower than one bit.
  function automatic int unsigned gate_cnt_w(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/bcd_decade.sv
// One BCD decade: counts 0..9 on carry_in, wraps 9->0, synchronous clear.
module bcd_decade
  import freq_meter_pkg::*;
(
  input  logic       clock_text,
  input  logic       clear_n,
  input  logic       sync_clr,
  input  logic       carry_in,
  output logic [3:0] digit,
  output logic       is_nine
);

  logic [3:0] r_digit;

  always_ff @(posedge clock_text or negedge clear_n) begin
    if (!clear_n) begin
      r_digit <= '0;
    end else if (sync_clr) begin
      r_digit <= '0;
    end else if (carry_in) begin
      r_digit <= (r_digit == BCD_MAX) ? 4'd0 : r_digit + 4'd1;
    end
  end

  assign digit   = r_digit;
  assign is_nine = (r_digit == BCD_MAX);

endmodule

// File: rtl/bcd_gated_freq_counter.sv
// Gated BCD edge counter: synchronises sig_in, counts qualified edges over a
// fixed gate window, latches the result and a saturation flag each window.
module bcd_gated_freq_counter
  import freq_meter_pkg::*;
#(
  parameter int unsigned DIGITS      = 6,
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clock_text,
  input  logic                  clear_n,
  input  logic                  enable,
  input  logic                  sig_in,
  input  logic                  edge_mode,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic                  valid,
  output logic                  busy
);

  localparam int unsigned   CW        = gate_cnt_w(GATE_CYCLES);
  localparam int unsigned   BW        = 4 * DIGITS;
  localparam logic [CW-1:0] GATE_LAST = CW'(GATE_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   r_mode;
  logic                   r_sat;
  logic [CW-1:0]          r_gate_cnt;
  logic [BW-1:0]          r_bcd;
  logic                   r_ovf;
  logic                   r_valid;
  logic                   r_busy;

  logic                   w_sync_last;
  logic                   w_edge;
  logic                   w_start;
  logic                   w_count;
  logic                   w_restart;
  logic                   w_all_nine;
  logic [BW-1:0]          w_work;
  logic [DIGITS-1:0]      w_nine;
  logic [DIGITS-1:0]      w_carry;

  // Synchroniser chain followed by one history flop for edge detection.
  always_ff @(posedge clock_text or negedge clear_n) begin
    if (!clear_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_sync_last = r_sync[SYNC_STAGES-1];
  assign w_edge      = (w_sync_last != r_hist) && (r_mode || w_sync_last);

  always_ff @(posedge clock_text or negedge clear_n) begin
    if (!clear_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_count = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_next  = GATE;
          w_start = 1'b1;
        end
      end
      GATE: begin
        if (!enable) begin
          w_next = IDLE;
        end else begin
          w_count = w_edge;
          if (r_gate_cnt == GATE_LAST) w_next = LATCH;
        end
      end
      LATCH: begin
        w_next = enable ? GATE : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Window start and the latch cycle both begin a fresh measurement.
  assign w_restart = w_start || (r_state == LATCH);

  always_ff @(posedge clock_text or negedge clear_n) begin
    if (!clear_n) begin
      r_gate_cnt <= '0;
      r_sat      <= 1'b0;
      r_mode     <= 1'b0;
    end else if (w_restart) begin
      r_gate_cnt <= '0;
      r_sat      <= 1'b0;
      r_mode     <= edge_mode;
    end else begin
      if (r_state == GATE)        r_gate_cnt <= r_gate_cnt + CW'(1);
      if (w_count && w_all_nine)  r_sat      <= 1'b1;
    end
  end

  always_ff @(posedge clock_text or negedge clear_n) begin
    if (!clear_n) begin
      r_bcd   <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= (r_state == LATCH);
      r_busy  <= (w_next == GATE);
      if (r_state == LATCH) begin
        r_bcd <= w_work;
        r_ovf <= r_sat;
      end
    end
  end

  // Carry chain is blocked at the units decade once every decade reads 9.
  assign w_all_nine = &w_nine;
  assign w_carry[0] = w_count && !w_all_nine;

  for (genvar k = 0; k < int'(DIGITS); k++) begin : g_dec
    if (k > 0) begin : g_carry
      assign w_carry[k] = w_carry[k-1] && w_nine[k-1];
    end
    bcd_decade u_decade (
      .clock_text (clock_text),
      .clear_n    (clear_n),
      .sync_clr   (w_restart),
      .carry_in   (w_carry[k]),
      .digit      (w_work[4*k +: 4]),
      .is_nine    (w_nine[k])
    );
  end

  assign bcd_out  = r_bcd;
  assign overflow = r_ovf;
  assign valid    = r_valid;
  assign busy     = r_busy;

endmodule

// File: tb/tb_bcd_gated_freq_counter.sv
// Bench for bcd_gated_freq_counter: table-driven windows plus corner sequences,
// checked against constants and a sample-history reference model.
module tb_bcd_gated_freq_counter;

  localparam int GA   = 1000;
  localparam int GB   = 5000;
  localparam int SS   = 2;
  localparam int MAXC = 65536;

  typedef struct {
    bit          mode;
    int          npulse;
    int          hi;
    int          lo;
    bit          toggle;
    logic [11:0] exp_bcd;
    bit          exp_ovf;
  } vec_t;

  logic        clk;
  logic        clear_n;
  logic        en_a, en_b;
  logic        sig_in;
  logic        edge_mode;
  logic [11:0] bcd_a, bcd_b;
  logic        ovf_a, ovf_b, vld_a, vld_b, bsy_a, bsy_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit sv  [MAXC];
  bit emv [MAXC];
  vec_t tbl [8];

  bcd_gated_freq_counter #(.DIGITS(3), .GATE_CYCLES(GA), .SYNC_STAGES(SS)) u_dut_a (
    .clock_text(clk), .clear_n(clear_n), .enable(en_a), .sig_in(sig_in),
    .edge_mode(edge_mode), .bcd_out(bcd_a), .overflow(ovf_a), .valid(vld_a), .busy(bsy_a)
  );

  bcd_gated_freq_counter #(.DIGITS(3), .GATE_CYCLES(GB), .SYNC_STAGES(SS)) u_dut_b (
    .clock_text(clk), .clear_n(clear_n), .enable(en_b), .sig_in(sig_in),
    .edge_mode(edge_mode), .bcd_out(bcd_b), .overflow(ovf_b), .valid(vld_b), .busy(bsy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // History of what each DUT sampled at every rising edge, indexed by edge number.
  always @(posedge clk) begin
    if (cyc < MAXC) begin
      sv[cyc]  <= sig_in;
      emv[cyc] <= edge_mode;
    end
    cyc <= cyc + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    logic [11:0] r;
    int x;
    x = (v > 999) ? 999 : v;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Edges seen by the synchroniser whose pulse lands on gate edges s+1..s+g.
  function automatic int model_count(input int s, input int g);
    int n;
    bit m;
    n = 0;
    m = emv[s];
    for (int e = s + 1; e <= s + g; e++)
      if ((sv[e-SS] != sv[e-SS-1]) && (m || sv[e-SS])) n++;
    return n;
  endfunction

  task automatic sample(input bit b, output logic [11:0] bc, output logic ov,
                        output logic vl, output logic bs);
    if (b) begin bc = bcd_b; ov = ovf_b; vl = vld_b; bs = bsy_b; end
    else   begin bc = bcd_a; ov = ovf_a; vl = vld_a; bs = bsy_a; end
  endtask

  task automatic pulses(input int n, input int hi, input int lo);
    for (int p = 0; p < n; p++) begin
      sig_in = 1'b1; repeat (hi) @(negedge clk);
      sig_in = 1'b0; repeat (lo) @(negedge clk);
    end
  endtask

  // Waits for the window that started at edge s to report, then checks it.
  task automatic check_window(input bit b, input int s, input int g,
                              input logic [11:0] eb, input bit eo);
    logic [11:0] bc;
    logic ov, vl, bs, bprev;
    bit ok;
    int n;
    ok = 1'b0;
    bprev = 1'b1;
    for (int i = 0; i < g + 100; i++) begin
      @(negedge clk);
      sample(b, bc, ov, vl, bs);
      if (vl) begin ok = 1'b1; break; end
      bprev = bs;
    end
    chk("valid_seen", 32'(ok), 32'd1);
    chk("valid_latency", 32'(cyc), 32'(s + g + 2));
    chk("busy_in_latch", 32'(bprev), 32'd0);
    chk("result_bcd", 32'(bc), 32'(eb));
    chk("result_ovf", 32'(ov), 32'(eo));
    n = model_count(s, g);
    chk("model_bcd", 32'(bc), 32'(to_bcd(n)));
    chk("model_ovf", 32'(ov), 32'(n > 999));
    @(negedge clk);
    sample(b, bc, ov, vl, bs);
    chk("valid_one_cycle", 32'(vl), 32'd0);
  endtask

  task automatic run_row(input vec_t v);
    int s;
    @(negedge clk);
    edge_mode = v.mode;
    en_a = 1'b1;
    s = cyc;
    repeat (10) @(negedge clk);
    for (int p = 0; p < v.npulse; p++) begin
      if (v.toggle && p == v.npulse / 2) edge_mode = ~edge_mode;
      pulses(1, v.hi, v.lo);
    end
    check_window(1'b0, s, GA, v.exp_bcd, v.exp_ovf);
    en_a = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int s, s2, vc, n, m;
    vec_t r5;
    clear_n = 1'b0; en_a = 1'b0; en_b = 1'b0; sig_in = 1'b0; edge_mode = 1'b0;

    tbl[0] = '{mode: 1'b0, npulse: 37,  hi: 3, lo: 3, toggle: 1'b0, exp_bcd: 12'h037, exp_ovf: 1'b0};
    tbl[1] = '{mode: 1'b1, npulse: 37,  hi: 3, lo: 3, toggle: 1'b0, exp_bcd: 12'h074, exp_ovf: 1'b0};
    tbl[2] = '{mode: 1'b1, npulse: 37,  hi: 3, lo: 3, toggle: 1'b1, exp_bcd: 12'h074, exp_ovf: 1'b0};
    tbl[3] = '{mode: 1'b0, npulse: 0,   hi: 3, lo: 3, toggle: 1'b0, exp_bcd: 12'h000, exp_ovf: 1'b0};
    tbl[4] = '{mode: 1'b0, npulse: 200, hi: 2, lo: 2, toggle: 1'b0, exp_bcd: 12'h200, exp_ovf: 1'b0};
    for (int i = 5; i < 8; i++) begin
      m = int'($urandom_range(0, 1));
      n = int'($urandom_range(1, 120));
      tbl[i].mode    = m[0];
      tbl[i].npulse  = n;
      tbl[i].hi      = int'($urandom_range(3, 4));
      tbl[i].lo      = 3;
      tbl[i].toggle  = 1'b0;
      tbl[i].exp_bcd = to_bcd(m[0] ? 2 * n : n);
      tbl[i].exp_ovf = 1'b0;
    end
    r5 = '{mode: 1'b0, npulse: 5, hi: 3, lo: 3, toggle: 1'b0, exp_bcd: 12'h005, exp_ovf: 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_bcd_a", 32'(bcd_a), 32'd0);
    chk("rst_ovf_a", 32'(ovf_a), 32'd0);
    chk("rst_vld_a", 32'(vld_a), 32'd0);
    chk("rst_bsy_a", 32'(bsy_a), 32'd0);
    chk("rst_bcd_b", 32'(bcd_b), 32'd0);
    chk("rst_bsy_b", 32'(bsy_b), 32'd0);
    clear_n = 1'b1;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 8; i++) run_row(tbl[i]);

    // Abort mid-window: previous result must hold, no valid.
    run_row(tbl[0]);
    @(negedge clk);
    edge_mode = 1'b0; en_a = 1'b1; s = cyc;
    repeat (10) @(negedge clk);
    while (cyc < s + 490) pulses(1, 3, 3);
    while (cyc < s + 500) @(negedge clk);
    chk("abort_busy_before", 32'(bsy_a), 32'd1);
    en_a = 1'b0;
    vc = 0;
    repeat (GA + 50) begin
      @(negedge clk);
      if (vld_a) vc++;
    end
    chk("abort_no_valid", 32'(vc), 32'd0);
    chk("abort_hold_bcd", 32'(bcd_a), 32'h037);
    chk("abort_hold_ovf", 32'(ovf_a), 32'd0);
    chk("abort_idle", 32'(bsy_a), 32'd0);
    run_row(r5);

    // Asynchronous clear in the middle of an active window.
    @(negedge clk);
    edge_mode = 1'b1; en_a = 1'b1; s = cyc;
    while (cyc < s + 300) begin
      sig_in = ~sig_in;
      repeat (2) @(negedge clk);
    end
    chk("pre_clear_busy", 32'(bsy_a), 32'd1);
    chk("pre_clear_bcd", 32'(bcd_a), 32'h005);
    clear_n = 1'b0;
    #1;
    chk("clear_bcd", 32'(bcd_a), 32'd0);
    chk("clear_ovf", 32'(ovf_a), 32'd0);
    chk("clear_vld", 32'(vld_a), 32'd0);
    chk("clear_bsy", 32'(bsy_a), 32'd0);
    en_a = 1'b0; sig_in = 1'b0;
    repeat (3) @(negedge clk);
    clear_n = 1'b1;
    repeat (10) @(negedge clk);
    run_row(r5);

    // Edge pulse landing on the final gate cycle is counted.
    @(negedge clk);
    edge_mode = 1'b0; en_a = 1'b1; s = cyc;
    repeat (10) @(negedge clk);
    pulses(4, 3, 3);
    while (cyc < s + GA - SS) @(negedge clk);
    sig_in = 1'b1;
    check_window(1'b0, s, GA, 12'h005, 1'b0);
    en_a = 1'b0; sig_in = 1'b0;
    repeat (10) @(negedge clk);

    // Edge pulse landing on the LATCH cycle is lost to both windows.
    @(negedge clk);
    edge_mode = 1'b0; en_a = 1'b1; s = cyc;
    repeat (10) @(negedge clk);
    pulses(4, 3, 3);
    while (cyc < s + GA + 1 - SS) @(negedge clk);
    sig_in = 1'b1;
    check_window(1'b0, s, GA, 12'h004, 1'b0);
    s2 = s + GA + 1;
    check_window(1'b0, s2, GA, 12'h000, 1'b0);
    en_a = 1'b0; sig_in = 1'b0;
    repeat (10) @(negedge clk);

    // Saturation on the long-window instance, then recovery next window.
    @(negedge clk);
    edge_mode = 1'b0; en_b = 1'b1; s = cyc;
    repeat (10) @(negedge clk);
    pulses(1200, 2, 2);
    check_window(1'b1, s, GB, 12'h999, 1'b1);
    s2 = s + GB + 1;
    repeat (10) @(negedge clk);
    pulses(5, 3, 3);
    check_window(1'b1, s2, GB, 12'h005, 1'b0);
    en_b = 1'b0;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_gated_freq_counter.md
Name: bcd_gated_freq_counter

Overview:
- Parametrised successor to the fixed 6-decade cascaded BCD counter in the TTL frequency meter.
- Samples an asynchronous TTL input in the system clock domain and counts its edges in BCD over a programmable gate window.
- Latches the result and an overflow flag at the end of each window, then restarts, giving continuous measurement.
- Output feeds the display/readout logic directly as packed BCD digits.

Parameters:
- DIGITS, 6, number of BCD decades (1..8).
- GATE_CYCLES, 50000000, length of the gate window in clock_text cycles (≥2).
- SYNC_STAGES, 2, synchroniser flops on sig_in (≥2).

Ports:
- clock_text  in  1  system clock; all logic on its rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- enable  in  1  1 = run measurement windows; 0 = stop/abort.
- sig_in  in  1  asynchronous TTL input under test.
- edge_mode  in  1  0 = count rising edges only; 1 = count rising and falling edges. Sampled only at window start.
- bcd_out  out  4*DIGITS  latched result; digit k occupies bits [4k+3:4k]; digit 0 is units.
- overflow  out  1  latched; 1 = count saturated during that window.
- valid  out  1  one-cycle pulse when bcd_out/overflow are updated.
- busy  out  1  1 while in GATE state.

Behaviour:
- Reset (clear_n=0, async):
  - bcd_out=0, overflow=0, valid=0, busy=0.
  - Synchroniser flops, edge history, working count, gate counter and saturation flag = 0.
  - state=IDLE.
- Input path:
  - sig_in passes through SYNC_STAGES flops, then one history flop.
  - An edge pulse is asserted when the last sync stage differs from the history flop, qualified by the mode latched at window start: rising only (mode 0) or either edge (mode 1).
  - Latency from a sig_in transition to the edge pulse is SYNC_STAGES+1 cycles.
- FSM states: IDLE, GATE, LATCH.
  - IDLE: if enable=1, go to GATE next cycle. On that transition, clear the gate counter, working count and saturation flag, and latch edge_mode.
  - GATE: busy=1; gate counter increments each cycle. Each edge pulse adds 1 to the BCD working count. When gate counter = GATE_CYCLES-1, go to LATCH; an edge in that final cycle is counted. If enable=0 in any GATE cycle, go to IDLE with no latch and no valid; bcd_out/overflow hold previous values; that cycle's edge is discarded.
  - LATCH (exactly 1 cycle): bcd_out<=working count, overflow<=saturation flag, valid=1. Working count, gate counter and saturation flag are cleared; edge_mode is re-latched. Edges in this cycle are dropped (one dead cycle per window). Next state is GATE if enable=1, else IDLE.
- BCD arithmetic:
  - Each decade counts 0..9.
  - A decade's carry-in is (edge pulse AND all lower decades = 9).
  - A decade wraps 9->0 on carry-in.
- Saturation: an edge pulse while all DIGITS decades = 9 leaves the count at all 9s and sets the saturation flag. The flag is sticky until the window ends.
- A new edge_mode value takes effect only at the next window start.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package (freq_meter_pkg):
  - State encoding constants IDLE/GATE/LATCH.
  - BCD_MAX = 4'd9.
  - Function for gate counter width = clog2(GATE_CYCLES).
- One sub-module: bcd_decade, a single decade.
  - Inputs: clock_text, clear_n, sync_clr, carry_in.
  - Outputs: digit[3:0], is_nine.
  - Instantiated DIGITS times in a generate loop.
  - Top level handles saturation gating of the carry chain.

Test Plan (DIGITS=3, GATE_CYCLES=1000 unless noted):
1. clear_n pulsed low mid-GATE with edges active -> all outputs 0 immediately (async). First valid arrives exactly GATE_CYCLES+2 cycles after enable rises post-reset.
2. edge_mode=0, exactly 37 rising edges (pulses ≥3 cycles high/low) placed ≥10 cycles inside the window -> valid pulse, bcd_out=12'h037, overflow=0, busy=0 during LATCH.
3. Same stimulus with edge_mode=1 -> bcd_out=12'h074. Toggle edge_mode mid-window -> result unchanged until the next window.
4. GATE_CYCLES=5000, 1200 rising edges at period 4 -> bcd_out=12'h999, overflow=1. Following window with 5 edges -> bcd_out=12'h005, overflow=0.
5. Prior result 12'h037 latched; enable dropped at gate cycle 500 -> no valid, bcd_out stays 12'h037, state IDLE. Re-enable -> fresh full window.
6. Edge timed so its pulse lands in the final gate cycle -> counted (N+1). Edge pulse in the LATCH cycle -> dropped from both windows.
